// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq -- iterative RV32M multiply/divide sequencer.
//
// One operation in flight at a time. A shared 32-step datapath does
// shift-add multiplication and restoring division on operand magnitudes.
// Signs are applied at the end of the run.
//
// Ports
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   req_valid/ready: request handshake (ready only in IDLE)
//   req_op         : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   req_a, req_b   : rs1 / rs2 values
//   req_rd         : destination register tag
//   resp_valid/ready: response handshake
//   resp_data      : 32-bit result
//   resp_rd        : tag for resp_data
//   busy           : high while CALC or DONE (stalls the pipeline)
//   flush          : abort any operation; no response is produced
// ---------------------------------------------------------------------------
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        busy,
    input  logic        flush
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;

    logic [2:0]  op_q;
    logic        neg_a, neg_b;   // latched operand signs (signed operands only)
    logic [4:0]  count;
    logic [31:0] hi, lo;         // {hi, lo}: accumulator/multiplier or {rem, quo}
    logic [31:0] opnd;           // multiplicand or divisor magnitude

    // ---------------- accept-time decode ----------------
    logic        accept;
    logic        a_signed, b_signed, a_neg_in, b_neg_in;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, special;
    logic [31:0] special_res;

    assign accept   = req_valid && req_ready && !flush;

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
    assign a_signed = (req_op == 3'b001) || (req_op == 3'b010) ||
                      (req_op == 3'b100) || (req_op == 3'b110);
    assign b_signed = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
    assign a_neg_in = a_signed && req_a[31];
    assign b_neg_in = b_signed && req_b[31];
    assign a_mag    = a_neg_in ? (32'd0 - req_a) : req_a;
    assign b_mag    = b_neg_in ? (32'd0 - req_b) : req_b;

    assign div_zero = req_op[2] && (req_b == 32'd0);
    assign div_ovf  = req_op[2] && !req_op[0] &&
                      (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;

    // req_op[1] distinguishes REM/REMU from DIV/DIVU within the divide group.
    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = req_op[1] ? req_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            special_res = req_op[1] ? 32'd0 : 32'h8000_0000;
    end

    // ---------------- one datapath step ----------------
    logic [32:0] mul_sum;
    logic [32:0] rem_sh, diff;
    logic [31:0] step_hi, step_lo;

    // Multiply: conditional add into the upper half, then shift the whole
    // 64-bit accumulator right; the carry drops into bit 63.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);

    // Divide: shift {rem, quo} left, trial-subtract; borrow means restore.
    assign rem_sh  = {hi, lo[31]};
    assign diff    = rem_sh - {1'b0, opnd};

    always_comb begin
        if (op_q[2]) begin
            step_hi = diff[32] ? rem_sh[31:0] : diff[31:0];
            step_lo = {lo[30:0], ~diff[32]};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], lo[31:1]};
        end
    end

    // ---------------- sign fix-up and result select ----------------
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix, result;

    assign prod     = {step_hi, step_lo};
    assign prod_fix = (neg_a ^ neg_b) ? (64'd0 - prod) : prod;
    assign quo_fix  = (neg_a ^ neg_b) ? (32'd0 - step_lo) : step_lo;
    assign rem_fix  = neg_a ? (32'd0 - step_hi) : step_hi;

    always_comb begin
        case (op_q)
            3'b000:                 result = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[63:32];
            3'b100, 3'b101:         result = quo_fix;
            default:                result = rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (count == 5'd0) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // flush overrides everything, including a DONE handshake
        if (flush) state_nxt = IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 3'd0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            count     <= 5'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            opnd      <= 32'd0;
            resp_data <= 32'd0;
            resp_rd   <= 5'd0;
        end else if (state == IDLE && accept) begin
            op_q    <= req_op;
            neg_a   <= a_neg_in;
            neg_b   <= b_neg_in;
            resp_rd <= req_rd;
            hi      <= 32'd0;
            // multiply: lo holds the multiplier; divide: lo holds the dividend
            lo      <= req_op[2] ? a_mag : b_mag;
            opnd    <= req_op[2] ? b_mag : a_mag;
            if (special) begin
                resp_data <= special_res;
                count     <= 5'd0;
            end else begin
                count     <= 5'd31;
            end
        end else if (state == CALC && !flush) begin
            hi <= step_hi;
            lo <= step_lo;
            if (count == 5'd0) resp_data <= result;
            else               count     <= count - 5'd1;
        end
    end

    // ---------------- outputs ----------------
    assign req_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq -- self-checking bench for muldiv_seq.
//
// A behavioural model tracks the single in-flight operation: when it was
// accepted, when its response is due (1 or 33 cycles later), and its value
// computed with plain 64-bit arithmetic. A negedge process compares every
// output each cycle against that model. Directed cases from the test plan
// also carry literal expected values.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        busy;
    logic        flush;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .busy       (busy),
        .flush      (flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 32'd0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                q = sa / sb; return 32'(q);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                q = sa % sb; return 32'(q);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // ---------------- behavioural model of the handshake ----------------
    int          cyc;
    int          due;
    logic        in_flight;
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            cyc       <= 0;
            due       <= 0;
            exp_data  <= 32'd0;
            exp_rd    <= 5'd0;
        end else begin
            cyc <= cyc + 1;
            if (flush)
                in_flight <= 1'b0;
            else if (in_flight) begin
                if (cyc >= due && resp_ready) in_flight <= 1'b0;
            end else if (req_valid) begin
                in_flight <= 1'b1;
                due       <= cyc + (is_special(req_op, req_a, req_b) ? 1 : 33);
                exp_data  <= ref_op(req_op, req_a, req_b);
                exp_rd    <= req_rd;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_v;
        if (!rst_n) begin
            chk("reset resp_valid", 32'(resp_valid), 32'd0);
            chk("reset busy", 32'(busy), 32'd0);
            chk("reset req_ready", 32'(req_ready), 32'd0);
            chk("reset resp_data", resp_data, 32'd0);
            chk("reset resp_rd", 32'(resp_rd), 32'd0);
        end else begin
            exp_v = in_flight && (cyc >= due);
            chk("req_ready", 32'(req_ready), 32'(!in_flight));
            chk("busy", 32'(busy), 32'(in_flight));
            chk("resp_valid", 32'(resp_valid), 32'(exp_v));
            if (exp_v && resp_valid) begin
                chk("resp_data", resp_data, exp_data);
                chk("resp_rd", 32'(resp_rd), 32'(exp_rd));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_resp(input string name, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk({name, " timeout"}, 32'(resp_valid), 32'd1);
    endtask

    // Issue one op (unit must be idle), wait for its response, hold
    // resp_ready low for `delay` cycles, then complete the handshake.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int delay, output logic [31:0] got);
        logic ok;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp("do_op", ok);
        got = resp_data;
        repeat (delay) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] got;
        logic        ok;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
        req_rd = 5'd0; resp_ready = 1'b0; flush = 1'b0;

        // pin the model to hand-computed values
        chk("model MUL", ref_op(3'd0, 32'd7, 32'd6), 32'd42);
        chk("model MULHU", ref_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("model MULH", ref_op(3'd1, 32'hFFFF_FFFE, 32'd3), 32'hFFFF_FFFF);
        chk("model DIV", ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model REM", ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // directed test-plan cases
        do_op(3'd0, 32'd7, 32'd6, 5'd1, 0, got);                      chk("MUL 7*6", got, 32'h0000_002A);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1, got);      chk("MULHU", got, 32'hFFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd3, 0, got);              chk("MULH -2*3", got, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 0, got);              chk("MULHSU -1*2", got, 32'hFFFF_FFFF);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, got);              chk("DIV -7/2", got, 32'hFFFF_FFFD);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, got);              chk("REM -7%2", got, 32'hFFFF_FFFF);
        do_op(3'd5, 32'd100, 32'd7, 5'd7, 0, got);                    chk("DIVU 100/7", got, 32'd14);
        do_op(3'd7, 32'd100, 32'd7, 5'd8, 0, got);                    chk("REMU 100%7", got, 32'd2);
        do_op(3'd4, 32'd1234, 32'd0, 5'd9, 0, got);                   chk("DIV by 0", got, 32'hFFFF_FFFF);
        do_op(3'd7, 32'd5, 32'd0, 5'd10, 0, got);                     chk("REMU 5%0", got, 32'd5);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, got);     chk("DIV ovf", got, 32'h8000_0000);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, got);     chk("REM ovf", got, 32'd0);

        // backpressure: model checks stability and req_ready low each cycle
        do_op(3'd0, 32'd123, 32'd456, 5'd13, 10, got);                chk("MUL backpressure", got, 32'd56088);

        // flush in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd3; req_rd = 5'd14;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("flush idle no accept", 32'(busy), 32'd0);

        // flush wins over a DONE handshake
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_a = 32'd5; req_b = 32'd0; req_rd = 5'd15;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; resp_ready = 1'b0;

        // flush in CALC cycle 15, new request the next cycle
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd5; req_a = 32'd1000; req_b = 32'd9; req_rd = 5'd16;
        @(negedge clk);                // cycle 1
        req_valid = 1'b0;
        repeat (14) @(negedge clk);    // cycle 15
        flush = 1'b1;
        @(negedge clk);                // cycle 16
        flush = 1'b0;
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd11; req_b = 32'd13; req_rd = 5'd17;
        @(negedge clk);
        req_valid = 1'b0;
        chk("accept after flush", 32'(busy), 32'd1);
        wait_resp("after flush", ok);
        chk("after flush rd", 32'(resp_rd), 32'd17);
        chk("after flush data", resp_data, 32'd143);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // reset mid-CALC
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'h1234_5678; req_b = 32'h8765_4321; req_rd = 5'd18;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst resp_valid", 32'(resp_valid), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst resp_data", resp_data, 32'd0);
        chk("async rst resp_rd", 32'(resp_rd), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);   // model flags any stray response

        // randomized operations
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = rnd_opnd();
            b  = rnd_opnd();
            do_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3), got);
            chk("random result", got, ref_op(op, a, b));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
